// File: rtl/loader_pkg.sv
// Shared types and default sizes for the switch-driven instruction memory loader.
package loader_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

endpackage

// File: rtl/switch_loader_edge_detect.sv
// Registered rising/falling edge detector for the Load switch level.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;
  logic seen_low_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q      <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
      if (!sig_i) seen_low_q <= 1'b1;
    end
  end

  // A switch already high when reset releases must be cycled before it counts as a rise.
  assign rise_o = sig_i & ~sig_q & seen_low_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/switch_loader.sv
// Loads words from board switches into processor instruction memory, one Strobe per word.
module switch_loader
  import loader_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              strobe_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              wr_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic              hold_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovr_q, ovr_d;
  logic              done_q, done_d;
  logic              stop_q, stop_d;
  logic              load_rise, load_fall;

  edge_detect u_load_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (load_i),
    .rise_o (load_rise),
    .fall_o (load_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_rise) begin
          state_d = ST_ARMED;
          addr_d  = '0;
          count_d = '0;
          ovr_d   = 1'b0;
          stop_d  = 1'b0;
        end
      end
      ST_ARMED: begin
        if (load_fall) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (strobe_i) begin
          data_d  = data_i;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (strobe_i) ovr_d = 1'b1;
        // Remember a Load drop so the session still ends if the switch bounces back high.
        if (load_fall) stop_d = 1'b1;
        if (wr_ready_i) begin
          addr_d = addr_q + 1'b1;
          if (count_q != DEPTH) count_d = count_q + 1'b1;
          if (stop_q || !load_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else if (addr_q == LAST) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_FULL: begin
        if (load_fall) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (strobe_i) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en_o   = (state_q == ST_WRITE);
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign hold_o    = (state_q != ST_IDLE);
  assign count_o   = count_q;
  assign done_o    = done_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_switch_loader.sv
// Directed and randomized checks of switch_loader against a session-level reference model.
module tb_switch_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, strobe, wr_ready;
  logic [15:0] data;
  logic        wr_en, hold, done, overrun;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a load session with a word count, an optional pending word.
  bit          m_active, m_pending, m_ovr, m_done, m_prev, m_seen_low, m_stop;
  int          m_count;
  logic [15:0] m_pdata;

  always #5 clk = ~clk;

  switch_loader dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .strobe_i   (strobe),
    .data_i     (data),
    .wr_ready_i (wr_ready),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .hold_o     (hold),
    .count_o    (count),
    .done_o     (done),
    .overrun_o  (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_ovr = 0; m_done = 0;
    m_prev = 0; m_seen_low = 0; m_stop = 0; m_count = 0; m_pdata = '0;
  endtask

  task automatic model_step();
    bit rise;
    rise   = load && !m_prev && m_seen_low;
    m_done = 0;
    if (!m_active) begin
      if (rise) begin
        m_active = 1; m_count = 0; m_ovr = 0; m_stop = 0;
      end
    end else if (m_pending) begin
      if (strobe) m_ovr = 1;
      if (!load) m_stop = 1;
      if (wr_ready) begin
        m_pending = 0;
        if (m_count < 128) m_count++;
        if (m_stop) begin
          m_active = 0; m_done = 1; m_stop = 0;
        end
      end
    end else begin
      if (!load) begin
        m_active = 0; m_done = 1;
      end else if (strobe) begin
        if (m_count == 128) m_ovr = 1;
        else begin
          m_pending = 1; m_pdata = data;
        end
      end
    end
    m_prev = load;
    if (!load) m_seen_low = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_en"},   wr_en,   m_pending);
    chk({tag, ".wr_addr"}, wr_addr, m_count % 128);
    chk({tag, ".wr_data"}, wr_data, m_pdata);
    chk({tag, ".hold"},    hold,    m_active);
    chk({tag, ".count"},   count,   m_count);
    chk({tag, ".done"},    done,    m_done);
    chk({tag, ".overrun"}, overrun, m_ovr);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic new_session();
    strobe = 0; load = 0;
    tick("sess_lo");
    load = 1;
    tick("sess_hi");
  endtask

  initial begin
    rst_n = 0; load = 0; strobe = 0; wr_ready = 0; data = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1;

    // Basic write with memory always ready
    tick("idle");
    load = 1;
    tick("rise");
    chk("rise.hold", hold, 1'b1);
    data = 16'hA5A5; strobe = 1; wr_ready = 1;
    tick("strobe");
    chk("a5.wr_en", wr_en, 1'b1);
    chk("a5.addr", wr_addr, 7'd0);
    chk("a5.data", wr_data, 16'hA5A5);
    strobe = 0;
    tick("hs");
    chk("a5.wr_en_drop", wr_en, 1'b0);
    chk("a5.count", count, 8'd1);

    // Stalled memory: outputs stable, extra strobe flags overrun
    wr_ready = 0; data = 16'h1234; strobe = 1;
    tick("stall_strobe");
    strobe = 0; data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      strobe = (i == 2);
      tick("stall");
      chk("stall.data", wr_data, 16'h1234);
      chk("stall.addr", wr_addr, 7'd1);
    end
    chk("stall.overrun", overrun, 1'b1);
    strobe = 0; wr_ready = 1;
    tick("stall_hs");

    // Fill all 128 words, then a dropped strobe
    new_session();
    chk("fill.ovr_cleared", overrun, 1'b0);
    for (int i = 0; i < 128; i++) begin
      data = 16'(i); strobe = 1; wr_ready = 1;
      tick("fill_strobe");
      chk("fill.addr", wr_addr, 32'(i));
      strobe = 0;
      tick("fill_hs");
    end
    chk("full.count", count, 8'd128);
    strobe = 1; data = 16'hBEEF;
    tick("full_strobe");
    chk("full.overrun", overrun, 1'b1);
    chk("full.no_wr_en", wr_en, 1'b0);
    strobe = 0;
    tick("full_idle");

    // Load drops during a stalled write; memory answers 3 cycles later
    new_session();
    data = 16'(($urandom)); strobe = 1; wr_ready = 0;
    tick("drop_strobe");
    strobe = 0; load = 0;
    for (int i = 0; i < 3; i++) tick("drop_wait");
    chk("drop.pending", wr_en, 1'b1);
    wr_ready = 1;
    tick("drop_hs");
    tick("drop_after");
    chk("drop.hold", hold, 1'b0);

    // Load drops then bounces high before the handshake: session still ends
    new_session();
    data = 16'(($urandom)); strobe = 1; wr_ready = 0;
    tick("bounce_strobe");
    strobe = 0; load = 0;
    tick("bounce_lo");
    load = 1;
    tick("bounce_hi");
    wr_ready = 1;
    tick("bounce_hs");
    chk("bounce.done", done, 1'b1);

    // Strobe coincides with Load falling in ARMED
    new_session();
    strobe = 1; load = 0; data = 16'h5A5A;
    tick("tie");
    chk("tie.wr_en", wr_en, 1'b0);
    chk("tie.done", done, 1'b1);
    chk("tie.overrun", overrun, 1'b0);
    strobe = 0;
    tick("tie_after");

    // Asynchronous reset mid-write; Load held high must not restart a session
    new_session();
    data = 16'hC0DE; strobe = 1; wr_ready = 0;
    tick("rst_strobe");
    strobe = 0;
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("rst.wr_en_now", wr_en, 1'b0);
    check_all("rst_mid");
    #2 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      strobe = (i == 1);
      tick("rst_hold_high");
    end
    chk("rst.no_session", hold, 1'b0);

    // Randomized traffic with occasional Load toggles
    strobe = 0;
    new_session();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) load = ~load;
      strobe   = ($urandom_range(0, 2) == 0);
      wr_ready = ($urandom_range(0, 1) == 0);
      data     = 16'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_loader.md
SWITCH_LOADER -- requirements
Module: switch_loader

Interface
REQ-001 Parameter WIDTH, 16, data word width written into processor instruction memory.
REQ-002 Parameter ADDR_W, 7, memory address width; depth = 2**ADDR_W (128 words).
REQ-003 Clock  input  1  single system clock; all state changes on rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Load  input  1  level from board switch; high = loader owns memory, low = processor runs.
REQ-006 Strobe  input  1  one-cycle pulse from the key filter; commits the current Data word.
REQ-007 Data  input  WIDTH  word to write, taken from the board switches.
REQ-008 WrReady  input  1  memory accepts write in any cycle where WrEn and WrReady are both high.
REQ-009 WrEn  output  1  write request to memory.
REQ-010 WrAddr  output  ADDR_W  write address.
REQ-011 WrData  output  WIDTH  registered write data.
REQ-012 Hold  output  1  high holds the processor in reset while loading.
REQ-013 Count  output  ADDR_W+1  number of words written since the current load session began (0..128).
REQ-014 Done  output  1  one-cycle pulse when a load session ends.
REQ-015 Overrun  output  1  sticky flag: a Strobe was dropped; clears at the start of the next session.

Function
REQ-016 FSM states: IDLE, ARMED, WRITE, FULL.
REQ-017 IDLE: a Load rising edge (registered low-to-high) moves to ARMED; WrAddr, Count and Overrun clear to 0; Hold goes high on the same edge.
REQ-018 ARMED: Strobe registers Data into WrData and moves to WRITE; WrEn is high starting the next cycle (1-cycle latency from Strobe).
REQ-019 WRITE: WrEn, WrAddr and WrData stay stable until WrReady is sampled high; on that edge WrEn drops, WrAddr and Count increment.
REQ-020 WRITE handshake complete with WrAddr = 2**ADDR_W-1: WrAddr wraps to 0, Count = 128, move to FULL.
REQ-021 WRITE handshake complete with WrAddr below the last address: return to ARMED.
REQ-022 Strobe in WRITE or FULL is not queued; it sets Overrun.
REQ-023 Strobe in IDLE is ignored and does not set Overrun.
REQ-024 Load low in ARMED or FULL: move to IDLE, Hold drops, Done pulses for one cycle.
REQ-025 Load low in WRITE: finish the pending handshake first, then go to IDLE with Done; no new write starts.
REQ-026 Load low in WRITE with a simultaneous handshake edge: count the word, then go to IDLE with Done on that edge.
REQ-027 Strobe and a Load falling edge in the same ARMED cycle: Load wins; no write; Overrun not set.
REQ-028 Count saturates at 128; it holds its value after leaving a session until the next Load rising edge.

Reset
REQ-029 Reset_n low: state IDLE, WrEn 0, WrAddr 0, WrData 0, Hold 0, Count 0, Done 0, Overrun 0, Load edge register 0.
REQ-030 Reset mid-WRITE abandons the transfer immediately; WrEn is low while Reset_n is low.
REQ-031 After Reset_n rises with Load already high, no session starts until Load goes low and then high again.

Structure
REQ-032 Shared package loader_pkg: state enum type, WIDTH and ADDR_W default constants.
REQ-033 One sub-module, edge_detect: a registered rising/falling edge detector for Load, with the same Clock/Reset_n.
REQ-034 Target size is 120-400 RTL lines; no memory inside the block, only the write port.

Verification
REQ-035 Load 0->1, Strobe with Data=16'hA5A5, WrReady held 1 -> WrEn high one cycle, WrAddr=0, WrData=A5A5, Count=1.
REQ-036 WrReady held 0 for 5 cycles after Strobe with Data=16'h1234 -> WrEn/WrAddr/WrData stable all 5 cycles; second Strobe sets Overrun=1.
REQ-037 128 strobes, data = index -> addresses 0..127 written, state FULL, Count=128; 129th strobe sets Overrun, no WrEn.
REQ-038 Load falls during WRITE, WrReady arrives 3 cycles later -> write completes, then Done pulse, Hold=0.
REQ-039 Reset_n pulsed low mid-WRITE -> WrEn=0 at once, all outputs at reset values; Load held high gives no new session.
REQ-040 Strobe and Load fall in the same cycle in ARMED -> no WrEn, Done pulses, Overrun=0.
